prod_accum: RTL
===============

Name: prod_accum

Overview:
- Downstream consumer of the `comp` multiplier stage: takes its two `2*p_size`-bit products (`o_param`, `o_param_2`) and the `dv` strobe.
- Accumulates each channel over a frame of `p_len` valid samples.
- Presents both frame sums on a valid/ready output held in a separate output register, so accumulation of the next frame continues while the consumer stalls.

Parameters:
- `p_size`, 12: operand width of the upstream `comp` stage; each input product is `2*p_size` bits.
- `p_len`, 16: valid samples per frame; legal range 2 to 65535.
- `ACC_W` (localparam), `2*p_size + $clog2(p_len)`: accumulator and output sum width; sized so no overflow is possible.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_param`, in, `2*p_size`: channel 0 product, unsigned (from `comp.o_param`).
- `i_param_2`, in, `2*p_size`: channel 1 product, unsigned (from `comp.o_param_2`).
- `i_dv`, in, 1: input sample valid (from `comp.dv`); no backpressure upstream.
- `clr`, in, 1: synchronous frame restart.
- `o_sum`, out, `ACC_W`: channel 0 frame sum.
- `o_sum_2`, out, `ACC_W`: channel 1 frame sum.
- `o_valid`, out, 1: sums valid.
- `i_ready`, in, 1: downstream accepts sums.
- `o_ovf`, out, 1: sticky flag, a completed frame was dropped.
- `o_cnt`, out, `$clog2(p_len)`: samples accumulated in the current frame.

Behaviour:
- Reset (async assert, sync deassert at the use site): `acc0`/`acc1`, `o_sum`, `o_sum_2`, `o_cnt` = 0; `o_valid` = 0; `o_ovf` = 0.
- Arithmetic: unsigned, zero-extended to `ACC_W`; never wraps or saturates.
- Accumulation, `i_dv`=1 and `clr`=0:
  - `o_cnt` < `p_len-1`: `acc <= acc + in`, `o_cnt <= o_cnt + 1`.
  - `o_cnt` == `p_len-1` (last sample): frame completes; `acc` <= 0 and `o_cnt` <= 0 in the same edge.
- Frame completion, final sums = `acc + in`:
  - If `o_valid`==0, or (`o_valid`==1 and `i_ready`==1): `o_sum`/`o_sum_2` <= final sums, `o_valid` <= 1.
  - Otherwise, output register occupied and stalled: sums dropped, `o_sum*`/`o_valid` unchanged, `o_ovf` <= 1.
- Latency: sums visible with `o_valid`=1 one cycle after the edge sampling the last `i_dv`.
- Output handshake:
  - Transfer occurs on any edge with `o_valid`&&`i_ready`.
  - After a transfer with no simultaneous completion, `o_valid` <= 0 and the sum registers hold their last value.
  - `o_sum*` are stable while `o_valid`=1 and `i_ready`=0.
- `i_dv`=0: `acc`/`o_cnt` hold; gaps of any length are legal.
- `clr`=1:
  - `acc` <= 0, `o_cnt` <= 0, `o_ovf` <= 0.
  - A coincident `i_dv` sample is discarded; `clr` has priority.
  - The output register and `o_valid` are unaffected; pending sums are still delivered.
- `o_ovf` is cleared only by `rst` or `clr`.
- Reset mid-frame: partial frame and any pending output are lost; no `o_valid` is produced for them.
- State is implicit (`o_cnt` plus `o_valid`); no separate FSM register is required.

Decomposition:
- Shared Verilog include `comp_defs.vh`:
  - `p_size` default.
  - `p_len` default.
  - Constant function `clog2`, used for `ACC_W`/`o_cnt` width by both `comp`-side and accumulator-side benches.
- One sub-module, `frame_cnt`:
  - Parameter `p_len`; inputs `clk`, `rst`, `inc`, `clr`.
  - Outputs `cnt` and `last` (`cnt`==`p_len-1`).
  - Instantiated once; the two accumulator channels are inline.

Test Plan (`p_size`=12, `p_len`=4, `ACC_W`=26, `i_ready`=1 unless stated):
- Basic frame: 4 back-to-back `i_dv` with `i_param`=1,2,3,4 and `i_param_2`=10,20,30,40 → one cycle after the 4th, `o_valid`=1, `o_sum`=10, `o_sum_2`=100; `o_cnt` back to 0; `o_valid` drops next cycle.
- Max values: 4 samples of `i_param` = `i_param_2` = 24'hFFFFFF → `o_sum` = `o_sum_2` = 26'h3FFFFFC; no wrap.
- Gapped input: same data as the basic frame with 3 idle cycles between samples → identical sums; `o_valid` exactly one cycle after the last `i_dv`.
- Backpressure and overflow:
  - Hold `i_ready`=0, send 8 samples of 1 → first frame `o_sum`=4 held stable, second frame dropped, `o_ovf`=1.
  - Raise `i_ready` → one transfer of 4, then `o_valid`=0.
  - Pulse `clr` → `o_ovf`=0.
- Simultaneous accept and complete: `o_valid`=1 with `i_ready`=1 on the same edge as a new last sample → new sums loaded, `o_valid` stays 1, no `o_ovf`.
- `clr`/reset mid-frame:
  - After 2 samples of 5, assert `clr` together with an `i_dv` of 7 → `o_cnt`=0; the next 4 samples of 1 give `o_sum`=4.
  - Asserting `rst` mid-frame instead → all outputs 0 immediately (async).

Source files
------------

// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg
//   Shared defaults and helpers for the product accumulator slice.
//   - P_SIZE_DEF : default operand width of the upstream multiplier stage
//                  (each product it emits is 2*P_SIZE_DEF bits wide).
//   - P_LEN_DEF  : default number of valid samples per frame.
//   - clog2()    : constant ceil(log2) helper, used to size the frame
//                  counter and the accumulator headroom bits.
package prod_accum_pkg;

    localparam int P_SIZE_DEF = 12;
    localparam int P_LEN_DEF  = 16;

    // Ceiling log2 for elaboration-time sizing. clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accum_frame_cnt.sv
// frame_cnt
//   Counts accepted samples within a frame of p_len samples and flags the
//   final slot of the frame.
// Ports:
//   clk  in  1      rising-edge clock
//   rst  in  1      asynchronous active-high reset, count returns to 0
//   inc  in  1      a sample is accepted this cycle
//   clr  in  1      synchronous restart, has priority over inc
//   cnt  out CNT_W  samples accumulated so far in the current frame
//   last out 1      cnt is at p_len-1, the next accepted sample ends the frame
module frame_cnt
    import prod_accum_pkg::*;
#(
    parameter  int p_len = P_LEN_DEF,
    localparam int CNT_W = clog2(p_len)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(p_len - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            // Wrap at the frame boundary rather than at 2**CNT_W, since
            // p_len need not be a power of two.
            if (cnt_q == LAST_IDX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/prod_accum.sv
// prod_accum
//   Accumulates two unsigned product streams over frames of p_len valid
//   samples and hands both frame sums to a downstream consumer through a
//   one-entry output register. Accumulation of the next frame continues
//   while the consumer stalls; a frame that completes while the output
//   register is still occupied and stalled is dropped and flagged.
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        asynchronous active-high reset
//   i_param    in  2*p_size channel 0 product (unsigned)
//   i_param_2  in  2*p_size channel 1 product (unsigned)
//   i_dv       in  1        input sample valid, no upstream backpressure
//   clr        in  1        synchronous frame restart, clears o_ovf
//   o_sum      out ACC_W    channel 0 frame sum
//   o_sum_2    out ACC_W    channel 1 frame sum
//   o_valid    out 1        sums valid
//   i_ready    in  1        downstream accepts sums
//   o_ovf      out 1        sticky: a completed frame was dropped
//   o_cnt      out CNT_W    samples accumulated in the current frame
//
// Output handshake: a transfer happens on every rising edge where
// o_valid && i_ready. While o_valid is high and i_ready is low, o_sum and
// o_sum_2 hold. o_valid only falls after a transfer that is not matched by
// a new frame completing on the same edge.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter  int p_size = P_SIZE_DEF,
    parameter  int p_len  = P_LEN_DEF,
    localparam int IN_W   = 2 * p_size,
    localparam int CNT_W  = clog2(p_len),
    localparam int ACC_W  = IN_W + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  i_param,
    input  logic [IN_W-1:0]  i_param_2,
    input  logic             i_dv,
    input  logic             clr,
    output logic [ACC_W-1:0] o_sum,
    output logic [ACC_W-1:0] o_sum_2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_cnt
);

    // ------------------------------------------------------------------
    // Frame position
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             last;

    frame_cnt #(
        .p_len (p_len)
    ) u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (i_dv),
        .clr  (clr),
        .cnt  (cnt),
        .last (last)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc0_d,  acc0_q;
    logic [ACC_W-1:0] acc1_d,  acc1_q;
    logic [ACC_W-1:0] sum0_d,  sum0_q;
    logic [ACC_W-1:0] sum1_d,  sum1_q;
    logic             valid_d, valid_q;
    logic             ovf_d,   ovf_q;

    // Running totals including the current sample; these are the final
    // sums when the current sample is the last one of the frame.
    logic [ACC_W-1:0] next0;
    logic [ACC_W-1:0] next1;
    logic             frame_done;
    logic             xfer;

    always_comb begin
        next0      = acc0_q + ACC_W'(i_param);
        next1      = acc1_q + ACC_W'(i_param_2);
        frame_done = i_dv && !clr && last;
        xfer       = valid_q && i_ready;
    end

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------
    always_comb begin
        acc0_d = acc0_q;
        acc1_d = acc1_q;
        if (clr) begin
            // A sample arriving with clr is discarded.
            acc0_d = '0;
            acc1_d = '0;
        end else if (i_dv) begin
            if (last) begin
                // Final sums leave through the output register; the
                // accumulators start the next frame from zero.
                acc0_d = '0;
                acc1_d = '0;
            end else begin
                acc0_d = next0;
                acc1_d = next1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        sum0_d  = sum0_q;
        sum1_d  = sum1_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (xfer) begin
            // Sum registers keep their last value after a transfer.
            valid_d = 1'b0;
        end

        if (frame_done) begin
            // The register is free if empty or being emptied on this edge.
            if (!valid_q || i_ready) begin
                sum0_d  = next0;
                sum1_d  = next1;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // clr restarts the frame and the overflow history, but any pending
        // sums are still delivered.
        if (clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc0_q  <= '0;
            acc1_q  <= '0;
            sum0_q  <= '0;
            sum1_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            sum0_q  <= sum0_d;
            sum1_q  <= sum1_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sum   = sum0_q;
    assign o_sum_2 = sum1_q;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;
    assign o_cnt   = cnt;

endmodule
